// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the display path: FSM encoding, BCD constants and
// the internal digit-count helper used by the converter and the display top.
package bin2bcd_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [3:0] BCD_NINE       = 4'h9;
   localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;

   // Digits needed to hold 2^width-1 (log10(2) ~ 0.3, rounded up).
   function automatic int ext_digits(input int width);
      return (width * 3) / 10 + 1;
   endfunction

endpackage

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more, so
// the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
   import bin2bcd_seq_pkg::*;
(
   input  logic [3:0] din,
   output logic [3:0] dout
);

   always_comb begin
      dout = din;
      if (din >= BCD_ADJ_THRESH) dout = din + 4'd3;
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) with
// saturation to all nines when the value needs more than DIGITS digits.
module bin2bcd_seq
   import bin2bcd_seq_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow
);

   // Handshake: start is a request sampled only while idle (busy=0); bin is
   // captured on that edge. Requests during busy are dropped, not queued.
   // done is a one-cycle pulse marking the cycle in which bcd/overflow change.

   localparam int EXT  = ext_digits(WIDTH);
   localparam int CW   = $clog2(WIDTH + 1);
   localparam int MAXD = (EXT > DIGITS) ? EXT : DIGITS;
   localparam int PW   = 4 * MAXD;

   state_t              state;
   logic [WIDTH-1:0]    bin_q;
   logic [4*EXT-1:0]    scratch;
   logic [4*EXT-1:0]    scratch_adj;
   logic [CW-1:0]       cnt;

   logic [PW-1:0]       scratch_wide;
   logic                result_ovf;
   logic [4*DIGITS-1:0] result_bcd;

   for (genvar g = 0; g < EXT; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .din  (scratch[4*g +: 4]),
         .dout (scratch_adj[4*g +: 4])
      );
   end

   // Widening to MAXD digits makes the DIGITS >= EXT case fall out naturally:
   // no digits above the display, so no overflow and zero-filled upper digits.
   always_comb begin
      scratch_wide = PW'(scratch);
      result_ovf   = |(scratch_wide >> (4 * DIGITS));
      result_bcd   = result_ovf ? {DIGITS{BCD_NINE}} : scratch_wide[4*DIGITS-1:0];
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         bin_q    <= '0;
         scratch  <= '0;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         bcd      <= '0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  bin_q   <= bin;
                  scratch <= '0;
                  cnt     <= CW'(WIDTH);
                  busy    <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               {scratch, bin_q} <= {scratch_adj, bin_q} << 1;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) state <= DONE;
            end
            DONE: begin
               bcd      <= result_bcd;
               overflow <= result_ovf;
               done     <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
